// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end for a 32K-word synchronous ROM with a 1-cycle
// read latency. It keeps a program counter, tracks the one read that may be
// in flight, and delivers fetched words to a valid/ready consumer. An output
// register plus a one-entry skid register let the pipeline absorb consumer
// backpressure without losing a word that is already in flight.
//
// Ports:
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   rom_address  out  [14:0] ROM read address (the pc register)
//   rom_out      in   [15:0] ROM data, valid one clk after rom_address
//   jump         in   redirect request (single-cycle qualifier)
//   jump_addr    in   [14:0] redirect target, sampled when jump=1
//   stall        in   1 = issue no new ROM read this cycle
//   instr        out  [15:0] fetched instruction word
//   instr_pc     out  [14:0] address instr was fetched from
//   instr_valid  out  instr/instr_pc hold a valid word
//   instr_ready  in   consumer accepts (transfer when valid & ready)
//   fetch_count  out  [31:0] saturating count of accepted words
//                     (present only when FETCH_PERF_EN is defined)
//
// Configuration macro: FETCH_PERF_EN adds the fetch_count counter and port.
// -----------------------------------------------------------------------------
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic [14:0] rom_address,
  input  logic [15:0] rom_out,
  input  logic        jump,
  input  logic [14:0] jump_addr,
  input  logic        stall,
  output logic [15:0] instr,
  output logic [14:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  // Architectural state
  logic [14:0] r_pc;
  logic        r_inflight;
  logic [14:0] r_inflight_pc;
  logic [15:0] r_instr;
  logic [14:0] r_instr_pc;
  logic        r_instr_valid;
  logic [15:0] r_skid_word;
  logic [14:0] r_skid_pc;
  logic        r_skid_valid;

  // Combinational control
  logic        w_pop;
  logic [1:0]  w_occ;
  logic [1:0]  w_occ_after_pop;
  logic        w_issue;

  // Next-state of the output and skid registers (ignoring jump)
  logic [15:0] w_instr_nxt;
  logic [14:0] w_instr_pc_nxt;
  logic        w_instr_valid_nxt;
  logic [15:0] w_skid_word_nxt;
  logic [14:0] w_skid_pc_nxt;
  logic        w_skid_valid_nxt;

  assign w_pop           = r_instr_valid & instr_ready;
  assign w_occ           = {1'b0, r_instr_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
  assign w_occ_after_pop = w_occ - {1'b0, w_pop};

  // A new read is only issued if, after this cycle's pop, there is room for
  // it to land in output+skid; this bounds buffering to two words.
  assign w_issue = ~jump & ~stall & (w_occ_after_pop <= 2'd1);

  // Route the returning ROM word and shift skid -> output on a pop.
  // NOTE: every variable gets a default first so this block cannot infer a latch.
  always_comb begin
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid & ~w_pop;
    w_skid_word_nxt   = r_skid_word;
    w_skid_pc_nxt     = r_skid_pc;
    w_skid_valid_nxt  = r_skid_valid;

    if (w_pop && r_skid_valid) begin
      // Skid advances into the output; a returning word backfills the skid.
      w_instr_nxt       = r_skid_word;
      w_instr_pc_nxt    = r_skid_pc;
      w_instr_valid_nxt = 1'b1;
      w_skid_word_nxt   = rom_out;
      w_skid_pc_nxt     = r_inflight_pc;
      w_skid_valid_nxt  = r_inflight;
    end else if (r_inflight) begin
      if (!r_instr_valid || w_pop) begin
        w_instr_nxt       = rom_out;
        w_instr_pc_nxt    = r_inflight_pc;
        w_instr_valid_nxt = 1'b1;
      end else begin
        // Output is held by the consumer: park the word in the skid.
        w_skid_word_nxt  = rom_out;
        w_skid_pc_nxt    = r_inflight_pc;
        w_skid_valid_nxt = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  // NOTE: the skid and output data registers are reset along with their valid
  // bits so instr/instr_pc read as zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_skid_word   <= '0;
      r_skid_pc     <= '0;
      r_skid_valid  <= 1'b0;
    end else if (jump) begin
      // Redirect flushes everything; the word held in instr/instr_pc is
      // simply invalidated (data left as-is).
      r_pc          <= jump_addr;
      r_inflight    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_skid_valid  <= 1'b0;
    end else begin
      r_inflight    <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 15'd1;  // natural 15-bit wrap 0x7FFF -> 0x0000
      end
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_skid_word   <= w_skid_word_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_skid_valid  <= w_skid_valid_nxt;
    end
  end

  assign rom_address = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

`ifdef FETCH_PERF_EN
  // Accepted-word counter; counts pops even on a jump cycle and is only
  // cleared by reset.
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_pop && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A synchronous ROM model returns
// {1'b0,addr} ^ 16'hA5A5 one clock after the address. The reference model
// keeps the delivered-word stream as a queue of fetch addresses plus the one
// in-flight read, and derives the expected outputs from that queue.
// Define FETCH_PERF_EN to also check fetch_count.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [14:0] rom_address;
  logic [15:0] rom_out;
  logic        jump;
  logic [14:0] jump_addr;
  logic        stall;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_address (rom_address),
    .rom_out     (rom_out),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, 1-cycle latency
  always @(posedge clk) rom_out <= {1'b0, rom_address} ^ 16'hA5A5;

  // Reference model state
  logic [14:0] m_q[$];        // delivered-order words currently buffered
  bit          m_inflight;
  logic [14:0] m_inflight_pc;
  logic [14:0] m_pc;
  logic [31:0] m_count;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_pc          = '0;
    m_count       = '0;
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic model_edge();
    bit pop;
    int occ;
    bit issue;
    if (!rst_n) return;
    pop = (m_q.size() > 0) && instr_ready;
    if (pop && (m_count != 32'hFFFF_FFFF)) m_count++;
    if (jump) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = jump_addr;
    end else begin
      occ   = m_q.size() + int'(m_inflight);
      issue = !stall && ((occ - int'(pop)) <= 1);
      if (pop) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_pc);
      m_inflight = issue;
      if (issue) begin
        m_inflight_pc = m_pc;
        m_pc          = m_pc + 15'd1;
      end
    end
  endtask

  task automatic check_all();
    check("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("instr_pc", 32'(instr_pc), 32'(m_q[0]));
      check("instr", 32'(instr), 32'(rom_word(m_q[0])));
    end
    check("rom_address", 32'(rom_address), 32'(m_pc));
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, m_count);
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_rom_address", 32'(rom_address), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst_fetch_count", fetch_count, 32'd0);
`endif
  endtask

  // One clock: apply inputs, take the edge, update model, compare.
  task automatic step(input logic j, input logic [14:0] ja, input logic s, input logic r);
    jump        = j;
    jump_addr   = ja;
    stall       = s;
    instr_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [15:0] exp_first[4];

  initial begin
    exp_first[0] = 16'hA5A5;
    exp_first[1] = 16'hA5A4;
    exp_first[2] = 16'hA5A7;
    exp_first[3] = 16'hA5A6;

    rst_n       = 1'b0;
    jump        = 1'b0;
    jump_addr   = '0;
    stall       = 1'b0;
    instr_ready = 1'b1;
    model_reset();
    #2;
    check_reset_outputs();
    repeat (2) step(1'b0, 15'd0, 1'b0, 1'b1);

    // Release reset mid-cycle; first issue happens on the next edge.
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 15'd0, 1'b0, 1'b1);
      if (k >= 1 && k <= 4) begin
        check("first_seq_pc", 32'(instr_pc), 32'(k - 1));
        check("first_seq_instr", 32'(instr), 32'(exp_first[k-1]));
      end
    end

    // Consumer backpressure for 5 cycles, then resume.
    repeat (5) step(1'b0, 15'd0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 15'd0, 1'b0, 1'b1);

    // Fill the skid, then jump while it is full.
    repeat (3) step(1'b0, 15'd0, 1'b0, 1'b0);
    step(1'b1, 15'h0100, 1'b0, 1'b0);
    check("jump_flush_valid", 32'(instr_valid), 32'd0);
    step(1'b0, 15'd0, 1'b0, 1'b1);
    step(1'b0, 15'd0, 1'b0, 1'b1);
    check("jump_target_pc", 32'(instr_pc), 32'h0100);
    check("jump_target_instr", 32'(instr), 32'hA4A5);
    repeat (3) step(1'b0, 15'd0, 1'b0, 1'b1);

    // pc wrap at the top of the address space.
    step(1'b1, 15'h7FFE, 1'b0, 1'b1);
    repeat (4) step(1'b0, 15'd0, 1'b0, 1'b1);
    check("wrap_pc", 32'(instr_pc), 32'h0000);
    repeat (2) step(1'b0, 15'd0, 1'b0, 1'b1);

    // Stall for 3 cycles: no flush, buffered words drain.
    repeat (3) step(1'b0, 15'd0, 1'b1, 1'b1);
    check("stall_drained", 32'(instr_valid), 32'd0);
    repeat (4) step(1'b0, 15'd0, 1'b0, 1'b1);

    // Stall combined with backpressure.
    repeat (2) step(1'b0, 15'd0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 15'd0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 15'd0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 15'd0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic        j;
      logic [14:0] ja;
      j  = ($urandom_range(15) == 0);
      ja = ($urandom_range(3) == 0) ? 15'(32'h7FFC + $urandom_range(3))
                                    : 15'($urandom_range(32767));
      step(j, ja, ($urandom_range(3) == 0), ($urandom_range(3) != 0));
    end

    // Reset pulsed mid-stream with words buffered and in flight.
    repeat (3) step(1'b0, 15'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    step(1'b0, 15'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (4) step(1'b0, 15'd0, 1'b0, 1'b1);
    check("refetch_pc", 32'(instr_pc), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
